// File: rtl/spi_master_apb_arbiter.sv
// rtl/spi_master_apb_arbiter.sv - round-robin APB arbiter with per-requester lock in front of apb_spi_master
// Optional lock watchdog is enabled by defining SPI_ARB_LOCK_TIMEOUT_EN.
module spi_master_apb_arbiter #(
  parameter int NB_MASTERS     = 2,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int LOCK_TIMEOUT   = 1024
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  input  logic [NB_MASTERS*APB_ADDR_WIDTH-1:0] S_PADDR,
  input  logic [NB_MASTERS*32-1:0]             S_PWDATA,
  input  logic [NB_MASTERS-1:0]                S_PWRITE,
  input  logic [NB_MASTERS-1:0]                S_PSEL,
  input  logic [NB_MASTERS-1:0]                S_PENABLE,
  output logic [NB_MASTERS*32-1:0]             S_PRDATA,
  output logic [NB_MASTERS-1:0]                S_PREADY,
  output logic [NB_MASTERS-1:0]                S_PSLVERR,
  input  logic [NB_MASTERS-1:0]                lock_i,
  input  logic                                 eot_i,
  output logic [APB_ADDR_WIDTH-1:0]            M_PADDR,
  output logic [31:0]                          M_PWDATA,
  output logic                                 M_PWRITE,
  output logic                                 M_PSEL,
  output logic                                 M_PENABLE,
  input  logic [31:0]                          M_PRDATA,
  input  logic                                 M_PREADY,
  input  logic                                 M_PSLVERR,
  output logic [NB_MASTERS-1:0]                grant_o,
  output logic                                 lock_timeout_o
);

  localparam int IW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         rr, owner, cur, winner;
  logic                  lock_valid, locked, win, wd_fire;
  logic [NB_MASTERS-1:0] req;
  int                    arb_idx;

  assign req = S_PSEL & S_PENABLE;

  // While a lock is held and still requested, only the owner may win.
  always_comb begin
    locked  = lock_valid && lock_i[owner];
    win     = 1'b0;
    winner  = rr;
    arb_idx = 0;
    for (int k = 1; k <= NB_MASTERS; k++) begin
      arb_idx = (int'(rr) + k) % NB_MASTERS;
      if (!win && req[arb_idx] && (!locked || owner == IW'(arb_idx))) begin
        win    = 1'b1;
        winner = IW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (M_PREADY) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr         <= IW'(NB_MASTERS - 1);
      owner      <= '0;
      cur        <= '0;
      lock_valid <= 1'b0;
      grant_o    <= '0;
      M_PADDR    <= '0;
      M_PWDATA   <= '0;
      M_PWRITE   <= 1'b0;
      M_PSEL     <= 1'b0;
      M_PENABLE  <= 1'b0;
      S_PRDATA   <= '0;
      S_PREADY   <= '0;
      S_PSLVERR  <= '0;
    end else begin
      S_PREADY  <= '0;
      M_PSEL    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      M_PENABLE <= (state_nxt == ACCESS);
      case (state)
        IDLE: if (win) begin
          M_PADDR  <= S_PADDR[int'(winner)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
          M_PWDATA <= S_PWDATA[int'(winner)*32 +: 32];
          M_PWRITE <= S_PWRITE[winner];
          grant_o  <= NB_MASTERS'(1) << winner;
          rr       <= winner;
          cur      <= winner;
        end
        ACCESS: if (M_PREADY) begin
          S_PRDATA[int'(cur)*32 +: 32] <= M_PRDATA;
          S_PSLVERR[cur]               <= M_PSLVERR;
          S_PREADY[cur]                <= 1'b1;
        end
        RESP: begin
          grant_o   <= '0;
          S_PRDATA  <= '0;
          S_PSLVERR <= '0;
        end
        default: ;
      endcase
      // Clears first so that a lock set on the same edge takes priority.
      if (eot_i || wd_fire) lock_valid <= 1'b0;
      if (state == IDLE && lock_valid && !lock_i[owner]) lock_valid <= 1'b0;
      if (state == ACCESS && M_PREADY && lock_i[cur]) begin
        lock_valid <= 1'b1;
        owner      <= cur;
      end
    end
  end

`ifdef SPI_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  assign wd_fire = lock_valid && !eot_i && (wd_cnt == CW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wd_cnt         <= '0;
      lock_timeout_o <= 1'b0;
    end else begin
      lock_timeout_o <= wd_fire;
      if (!lock_valid || eot_i || wd_fire) wd_cnt <= '0;
      else                                 wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire        = 1'b0;
  assign lock_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_apb_arbiter.sv
// tb/tb_spi_master_apb_arbiter.sv - directed self-checking bench for spi_master_apb_arbiter
module tb_spi_master_apb_arbiter;
  localparam int NB = 2;
  localparam int AW = 12;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [NB*AW-1:0]  S_PADDR;
  logic [NB*32-1:0]  S_PWDATA;
  logic [NB-1:0]     S_PWRITE, S_PSEL, S_PENABLE;
  logic [NB*32-1:0]  S_PRDATA;
  logic [NB-1:0]     S_PREADY, S_PSLVERR;
  logic [NB-1:0]     lock_i;
  logic              eot_i;
  logic [AW-1:0]     M_PADDR;
  logic [31:0]       M_PWDATA, M_PRDATA;
  logic              M_PWRITE, M_PSEL, M_PENABLE, M_PREADY, M_PSLVERR;
  logic [NB-1:0]     grant_o;
  logic              lock_timeout_o;

  int   total = 0;
  int   bad = 0;
  int   wait_cfg = 0;
  logic slverr_cfg = 1'b0;
  int   acc_cnt = 0;
  int   rdy1_cnt = 0;

  spi_master_apb_arbiter #(.NB_MASTERS(NB), .APB_ADDR_WIDTH(AW), .LOCK_TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA), .S_PWRITE(S_PWRITE),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .lock_i(lock_i), .eot_i(eot_i),
    .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PWRITE(M_PWRITE),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE),
    .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR),
    .grant_o(grant_o), .lock_timeout_o(lock_timeout_o)
  );

  always #5 HCLK = ~HCLK;

  // SPI-side responder: wait_cfg low cycles in ACCESS, read data tagged with the address.
  always @(posedge HCLK) begin
    if (M_PSEL && M_PENABLE && !M_PREADY) acc_cnt <= acc_cnt + 1;
    else                                  acc_cnt <= 0;
  end
  assign M_PREADY  = M_PSEL & M_PENABLE & (acc_cnt >= wait_cfg);
  assign M_PRDATA  = {20'hCAFE0, M_PADDR};
  assign M_PSLVERR = slverr_cfg & M_PREADY;

  always @(negedge HCLK) if (S_PREADY[1]) rdy1_cnt <= rdy1_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    HRESETn   = 1'b0;
    S_PADDR   = '0;
    S_PWDATA  = '0;
    S_PWRITE  = '0;
    S_PSEL    = '0;
    S_PENABLE = '0;
    lock_i    = '0;
    eot_i     = 1'b0;
    wait_cfg  = 0;
    slverr_cfg = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd);
    S_PADDR[idx*AW +: AW]  = addr;
    S_PWDATA[idx*32 +: 32] = wd;
    S_PWRITE[idx]          = wr;
    S_PSEL[idx]            = 1'b1;
    S_PENABLE[idx]         = 1'b1;
  endtask

  task automatic xfer(input int idx, input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic err);
    set_req(idx, wr, addr, wd);
    lat = -1;
    rd  = '0;
    err = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge HCLK);
      if (S_PREADY[idx]) begin
        lat = k;
        rd  = S_PRDATA[idx*32 +: 32];
        err = S_PSLVERR[idx];
        break;
      end
    end
    S_PSEL[idx]    = 1'b0;
    S_PENABLE[idx] = 1'b0;
  endtask

  initial begin
    int          lat, base;
    logic [31:0] rd;
    logic        err;

    do_reset();
    @(negedge HCLK);
    check("rst_grant", grant_o, 0);
    check("rst_msel", {M_PSEL, M_PENABLE, M_PWRITE}, 0);
    check("rst_sready", S_PREADY, 0);
    check("rst_prdata", S_PRDATA, 0);
    check("rst_maddr", M_PADDR, 0);
    check("rst_timeout", lock_timeout_o, 0);

    // 1: single write, cycle-exact
    do_reset();
    set_req(0, 1'b1, 12'h008, 32'h55);
    for (int k = 0; k < 5; k++) begin
      @(negedge HCLK);
      check("t1_psel", M_PSEL, (k == 1 || k == 2));
      check("t1_penable", M_PENABLE, (k == 2));
      check("t1_pready", S_PREADY, (k == 3) ? 2'b01 : 2'b00);
      if (k == 1) begin
        check("t1_pwdata", M_PWDATA, 32'h55);
        check("t1_paddr", M_PADDR, 12'h008);
        check("t1_pwrite", M_PWRITE, 1'b1);
        check("t1_grant", grant_o, 2'b01);
      end
      if (k == 3) begin
        S_PSEL    = '0;
        S_PENABLE = '0;
      end
      if (k == 4) begin
        check("t1_grant_clr", grant_o, 0);
        check("t1_prdata_clr", S_PRDATA, 0);
      end
    end

    // 2: two persistent readers alternate starting with 0
    do_reset();
    set_req(0, 1'b0, 12'h010, 32'h0);
    set_req(1, 1'b0, 12'h020, 32'h0);
    for (int n = 0; n < 4; n++) begin
      for (int t = 0; t < 20; t++) begin
        @(negedge HCLK);
        if (|S_PREADY) break;
      end
      if (n % 2 == 0) begin
        check("t2_order0", S_PREADY, 2'b01);
        check("t2_rdata0", S_PRDATA[31:0], 32'hCAFE0010);
        check("t2_other0", S_PRDATA[63:32], 0);
      end else begin
        check("t2_order1", S_PREADY, 2'b10);
        check("t2_rdata1", S_PRDATA[63:32], 32'hCAFE0020);
        check("t2_other1", S_PRDATA[31:0], 0);
      end
    end
    S_PSEL    = '0;
    S_PENABLE = '0;

    // 3: lock held by req0 blocks req1 until eot
    do_reset();
    lock_i[0] = 1'b1;
    base = rdy1_cnt;
    set_req(1, 1'b0, 12'h030, 32'h0);
    for (int n = 0; n < 3; n++) begin
      xfer(0, 1'b0, 12'h004, 32'h0, lat, rd, err);
      check("t3_lat", lat, 3);
      check("t3_rd", rd, 32'hCAFE0004);
    end
    repeat (3) @(negedge HCLK);
    check("t3_blocked", rdy1_cnt - base, 0);
    check("t3_idle_grant", grant_o, 0);
    eot_i = 1'b1;
    @(negedge HCLK);
    eot_i = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge HCLK);
      if (|S_PREADY) break;
    end
    check("t3_req1_ready", S_PREADY, 2'b10);
    check("t3_req1_grant", grant_o, 2'b10);
    check("t3_req1_rd", S_PRDATA[63:32], 32'hCAFE0030);
    S_PSEL    = '0;
    S_PENABLE = '0;
    lock_i    = '0;

    // 4: four wait states and slave error
    do_reset();
    wait_cfg   = 4;
    slverr_cfg = 1'b1;
    xfer(0, 1'b0, 12'h00C, 32'h0, lat, rd, err);
    check("t4_lat", lat, 7);
    check("t4_err", err, 1'b1);
    check("t4_rd", rd, 32'hCAFE000C);
    wait_cfg   = 0;
    slverr_cfg = 1'b0;

    // 5: reset during ACCESS, then a clean transfer
    do_reset();
    wait_cfg = 10;
    set_req(0, 1'b0, 12'h010, 32'h0);
    repeat (3) @(negedge HCLK);
    check("t5_in_access", M_PENABLE, 1'b1);
    HRESETn = 1'b0;
    #1;
    check("t5_msel", {M_PSEL, M_PENABLE}, 0);
    check("t5_grant", grant_o, 0);
    check("t5_maddr", M_PADDR, 0);
    check("t5_sready", S_PREADY, 0);
    S_PSEL    = '0;
    S_PENABLE = '0;
    wait_cfg  = 0;
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    xfer(0, 1'b0, 12'h014, 32'h0, lat, rd, err);
    check("t5_lat", lat, 3);
    check("t5_rd", rd, 32'hCAFE0014);
    check("t5_err", err, 1'b0);

`ifdef SPI_ARB_LOCK_TIMEOUT_EN
    // 6: watchdog breaks a stale lock, then req1 is served
    begin
      int to_k, r1_k, pulses;
      do_reset();
      to_k = -1;
      r1_k = -1;
      pulses = 0;
      lock_i[0] = 1'b1;
      set_req(0, 1'b0, 12'h004, 32'h0);
      set_req(1, 1'b0, 12'h040, 32'h0);
      for (int k = 0; k < 40; k++) begin
        @(negedge HCLK);
        if (S_PREADY[0]) begin
          S_PSEL[0]    = 1'b0;
          S_PENABLE[0] = 1'b0;
        end
        if (lock_timeout_o) begin
          pulses++;
          if (to_k < 0) to_k = k;
        end
        if (S_PREADY[1]) begin
          r1_k = k;
          break;
        end
      end
      check("t6_timeout_k", to_k, 19);
      check("t6_pulses", pulses, 1);
      check("t6_req1_k", r1_k, 22);
      S_PSEL    = '0;
      S_PENABLE = '0;
      lock_i    = '0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
